// File: rtl/jt900h_regdump_if.sv
// Dump-reader control/stream bundle: start/abort/status, register-file dump port,
// and the valid/ready byte stream toward the host link.
interface jt900h_regdump_if;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] dmp_addr;
  logic [7:0] dmp_din;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output start, abort, dmp_din, tx_ready,
    input  busy, done, dmp_addr, tx_data, tx_valid
  );

  modport slave (
    input  start, abort, dmp_din, tx_ready,
    output busy, done, dmp_addr, tx_data, tx_valid
  );
endinterface

// File: rtl/jt900h_regdump.sv
// Register-dump reader: sweeps the dump port and streams HDR, data bytes and a
// two's-complement checksum through a small FIFO.
//
// state | meaning
// IDLE  | waiting for start; FIFO empty
// READ  | issuing dump addresses, capturing one byte per issue
// CSUM  | pushing the checksum once the FIFO has room
// DRAIN | waiting for the FIFO to empty, then done
module jt900h_regdump #(
  parameter logic [7:0] LAST_ADDR = 8'h4F,
  parameter logic [7:0] HDR       = 8'hA5,
  parameter int         DEPTH     = 4
) (
  input logic            clk,
  input logic            rst_n,
  jt900h_regdump_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, CSUM, DRAIN} state_t;

  state_t        state, state_nx;
  logic [7:0]    fifo [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_pop;
  logic          inflight;
  logic [8:0]    nxt;
  logic [7:0]    sum;
  logic [7:0]    addr_r;
  logic          done_r;
  logic          pop, push, issue, clear, done_nx;
  logic [7:0]    push_data;

  assign pop          = (count != '0) && bus.tx_ready;
  assign count_pop    = count - (AW+1)'(pop);
  assign bus.tx_valid = (count != '0);
  assign bus.tx_data  = fifo[rd_ptr];
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;
  assign bus.dmp_addr = addr_r;

  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    push_data = bus.dmp_din;
    issue     = 1'b0;
    clear     = 1'b0;
    done_nx   = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        clear     = 1'b1;
        push      = 1'b1;
        push_data = HDR;
        state_nx  = READ;
      end
      READ: begin
        // Room must cover both the stored bytes and the one still in flight.
        issue = (nxt <= {1'b0, LAST_ADDR}) &&
                ((count_pop + (AW+1)'(inflight)) < DEPTH_C);
        if (inflight) begin
          push = 1'b1;
          if (addr_r == LAST_ADDR) state_nx = CSUM;
        end
      end
      CSUM: if (count_pop != DEPTH_C) begin
        push      = 1'b1;
        push_data = 8'd0 - sum;
        state_nx  = DRAIN;
      end
      DRAIN: if (count_pop == '0) begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: ;
    endcase
    if (bus.abort) begin
      state_nx = IDLE;
      push     = 1'b0;
      issue    = 1'b0;
      clear    = 1'b1;
      done_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      nxt      <= '0;
      sum      <= '0;
      addr_r   <= '0;
      done_r   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= 8'h00;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      done_r   <= done_nx;
      if (clear) begin
        rd_ptr <= '0;
        sum    <= '0;
        if (push) begin
          fifo[0] <= push_data;
          wr_ptr  <= AW'(1);
          count   <= (AW+1)'(1);
        end else begin
          wr_ptr <= '0;
          count  <= '0;
        end
      end else begin
        if (push) begin
          fifo[wr_ptr] <= push_data;
          wr_ptr       <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count_pop + (AW+1)'(push);
        if (push && state == READ) sum <= sum + bus.dmp_din;
      end
      if (clear && push) begin
        nxt    <= '0;
        addr_r <= '0;
      end else if (issue) begin
        addr_r <= nxt[7:0];
        nxt    <= nxt + 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_jt900h_regdump.sv
// Bench for jt900h_regdump: frame scoreboard built from the memory contents,
// per-cycle stream/done/occupancy checks, and directed timing/stall/abort/reset cases.
module tb_jt900h_regdump;
  localparam int         LAST  = 'h4F;
  localparam int         DEPTH = 4;
  localparam logic [7:0] HDR   = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  jt900h_regdump_if bus();

  jt900h_regdump #(.LAST_ADDR(8'h4F), .HDR(8'hA5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Register file model: dmp_addr is the address register, so data follows it.
  logic [7:0] mem [256];
  assign bus.dmp_din = mem[bus.dmp_addr];

  int n_cmp = 0, n_bad = 0, n_acc = 0, n_done = 0;
  int ready_mode = 0;
  logic [7:0] exp_q [$];
  logic done_exp = 1'b0, hold_prev = 1'b0;
  logic [7:0] hold_data, e, cs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, want, $time);
    end
  endtask

  task automatic expect_frame(output logic [7:0] csum);
    logic [7:0] s;
    s = 8'h00;
    exp_q.delete();
    exp_q.push_back(HDR);
    for (int a = 0; a <= LAST; a++) begin
      exp_q.push_back(mem[a]);
      s += mem[a];
    end
    csum = 8'h00 - s;
    exp_q.push_back(csum);
    n_acc = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, t;
    d0 = n_done;
    t  = 0;
    while (n_done == d0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("done_seen", 32'(n_done != d0), 1);
    chk("frame_consumed", exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = ($urandom_range(0, 99) < 30);
      default: bus.tx_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      done_exp  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      chk("done", bus.done, done_exp);
      if (bus.done) n_done++;
      done_exp = 1'b0;
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", bus.tx_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("stream_byte", bus.tx_data, e);
          n_acc++;
          if (exp_q.size() == 0) done_exp = 1'b1;
        end
      end
      if (hold_prev) chk("hold_stable", {bus.tx_valid, bus.tx_data}, {1'b1, hold_data});
      hold_prev = bus.tx_valid && !bus.tx_ready;
      hold_data = bus.tx_data;
      // Bytes produced or in flight, less those taken, must fit the FIFO.
      if (bus.busy) chk("occupancy_ok", 32'((int'(bus.dmp_addr) + 2 - n_acc) <= DEPTH), 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.tx_ready = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);
    #23;
    chk("rst_addr",  bus.dmp_addr, 0);
    chk("rst_data",  bus.tx_data, 0);
    chk("rst_valid", bus.tx_valid, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_done",  bus.done, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Ramp memory, ready high: reference timing.
    expect_frame(cs);
    chk("model_csum_ramp", cs, 8'hA8);
    pulse_start();
    chk("c1_busy", bus.busy, 1);
    chk("c1_valid", bus.tx_valid, 1);
    chk("c1_hdr", bus.tx_data, 8'hA5);
    chk("c1_addr", bus.dmp_addr, 0);
    @(posedge clk); #1;
    chk("c2_bubble", bus.tx_valid, 0);
    @(posedge clk); #1;
    chk("c3_byte0", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h00});
    repeat (79) @(posedge clk);
    #1 chk("c82_byte79", bus.tx_data, 8'h4F);
    @(posedge clk); #1;
    chk("c83_csum", bus.tx_data, 8'hA8);
    @(posedge clk); #1;
    chk("c84_done", bus.done, 1);
    chk("c84_busy", bus.busy, 0);

    // All-zero memory, started in the done cycle.
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    expect_frame(cs);
    chk("model_csum_zero", cs, 8'h00);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("b2b_busy", bus.busy, 1);
    wait_done(400);

    // Ramp with a 30% ready duty.
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);
    ready_mode = 1;
    expect_frame(cs);
    pulse_start();
    wait_done(3000);

    // Sink stalled: four bytes buffered, address stops at 02.
    ready_mode = 2;
    repeat (2) @(posedge clk);
    expect_frame(cs);
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    chk("stall_addr", bus.dmp_addr, 8'h02);
    chk("stall_head", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hA5});
    ready_mode = 0;
    wait_done(400);

    // Abort with address 0x20 in flight, then a fresh frame.
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h3C;
    expect_frame(cs);
    pulse_start();
    for (int t = 0; t < 200 && bus.dmp_addr != 8'h20; t++) begin
      @(posedge clk); #1;
    end
    chk("abort_reach", bus.dmp_addr, 8'h20);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    exp_q.delete();
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.tx_valid, 0);
    repeat (10) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_with_abort", bus.busy, 0);
    expect_frame(cs);
    pulse_start();
    wait_done(400);

    // Random contents, random ready, ignored mid-frame start.
    for (int f = 0; f < 3; f++) begin
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      ready_mode = 1;
      expect_frame(cs);
      pulse_start();
      repeat ($urandom_range(10, 120)) @(posedge clk);
      pulse_start();
      wait_done(3000);
    end

    // Asynchronous reset mid-frame.
    expect_frame(cs);
    pulse_start();
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_addr",  bus.dmp_addr, 0);
    chk("arst_data",  bus.tx_data, 0);
    chk("arst_valid", bus.tx_valid, 0);
    chk("arst_busy",  bus.busy, 0);
    chk("arst_done",  bus.done, 0);
    exp_q.delete();
    #20 rst_n = 1'b1;
    expect_frame(cs);
    pulse_start();
    wait_done(3000);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end
endmodule
